// File: rtl/trigger_capture_if.sv
// ADC sample stream, trigger controls and capture-RAM write port between adc_com, trigger_capture and the RAM.
// The master side is the sample/control source. The slave side is the capture engine.
interface trigger_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] trig_level;
  logic [DATA_W-1:0] trig_hyst;
  logic              trig_slope;
  logic              arm;
  logic              force_trig;
  logic              frame_ack;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [ADDR_W-1:0] trig_addr;
  logic              frame_ready;
  logic [2:0]        cap_state;

  modport master (
    output sample_valid, sample_data, trig_level, trig_hyst, trig_slope,
           arm, force_trig, frame_ack,
    input  buf_we, buf_addr, buf_data, trig_addr, frame_ready, cap_state
  );

  modport slave (
    input  sample_valid, sample_data, trig_level, trig_hyst, trig_slope,
           arm, force_trig, frame_ack,
    output buf_we, buf_addr, buf_data, trig_addr, frame_ready, cap_state
  );
endinterface

// File: rtl/trigger_capture.sv
// Hysteresis level trigger writing a circular pre-trigger plus fixed post-trigger frame into RAM.
// Writes land one cycle after sample_valid; no backpressure, and a finished frame is held until frame_ack.
module trigger_capture #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int PRE_TRIG = 256
) (
  input  logic             osc_clk,
  input  logic             reset,
  trigger_capture_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRETRIG = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic              hyst_ok_q, hyst_ok_d;
  logic              force_pend_q, force_pend_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              frame_ready_q, frame_ready_d;

  logic [DATA_W-1:0] low_thr, high_thr;
  logic [DATA_W:0]   high_sum;
  logic              wr_en, hyst_set, level_hit;

  // Band edges saturate instead of wrapping so extreme levels still arm sensibly.
  always_comb begin
    low_thr  = (bus.trig_level > bus.trig_hyst) ? (bus.trig_level - bus.trig_hyst) : '0;
    high_sum = {1'b0, bus.trig_level} + {1'b0, bus.trig_hyst};
    high_thr = high_sum[DATA_W] ? '1 : high_sum[DATA_W-1:0];
    if (bus.trig_slope) begin
      hyst_set  = (bus.sample_data <= low_thr);
      level_hit = hyst_ok_q && (bus.sample_data >= bus.trig_level);
    end else begin
      hyst_set  = (bus.sample_data >= high_thr);
      level_hit = hyst_ok_q && (bus.sample_data <= bus.trig_level);
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    hyst_ok_d    = hyst_ok_q;
    force_pend_d = force_pend_q;
    trig_addr_d  = trig_addr_q;
    buf_we_d     = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;

    wr_en = bus.sample_valid &&
            ((state_q == PRETRIG) || (state_q == ARMED) || (state_q == POST));
    if (wr_en) begin
      buf_we_d   = 1'b1;
      buf_addr_d = wr_ptr_q;
      buf_data_d = bus.sample_data;
      wr_ptr_d   = wr_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.arm) begin
          state_d   = PRETRIG;
          pre_cnt_d = '0;
        end
      end
      PRETRIG: begin
        if (bus.sample_valid) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_q == PRE_LAST) begin
            state_d      = ARMED;
            hyst_ok_d    = 1'b0;
            force_pend_d = 1'b0;
          end
        end
      end
      ARMED: begin
        if (bus.sample_valid) begin
          if (force_pend_q || bus.force_trig || level_hit) begin
            state_d      = (POST_LAST == '0) ? DONE : POST;
            trig_addr_d  = wr_ptr_q;
            post_cnt_d   = ADDR_W'(1);
            force_pend_d = 1'b0;
          end else if (hyst_set) begin
            hyst_ok_d = 1'b1;
          end
        end else if (bus.force_trig) begin
          force_pend_d = 1'b1;
        end
      end
      POST: begin
        if (bus.sample_valid) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_q == POST_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.frame_ack) begin
          state_d   = bus.arm ? PRETRIG : IDLE;
          pre_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Tracks the next state so the flag drops in the same cycle the FSM leaves DONE.
    frame_ready_d = (state_d == DONE);
  end

  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      hyst_ok_q     <= 1'b0;
      force_pend_q  <= 1'b0;
      trig_addr_q   <= '0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      hyst_ok_q     <= hyst_ok_d;
      force_pend_q  <= force_pend_d;
      trig_addr_q   <= trig_addr_d;
      buf_we_q      <= buf_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign bus.buf_we      = buf_we_q;
  assign bus.buf_addr    = buf_addr_q;
  assign bus.buf_data    = buf_data_q;
  assign bus.trig_addr   = trig_addr_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.cap_state   = state_q;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture at DEPTH=16, PRE_TRIG=4 (post window 12 samples).
// Expected addresses come from a bench-side write pointer; levels and states are hand-derived.
module tb_trigger_capture;
  logic osc_clk = 1'b0;
  logic reset   = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  logic [3:0] exp_ptr = '0;

  trigger_capture_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  trigger_capture #(.DATA_W(8), .ADDR_W(4), .PRE_TRIG(4)) dut (
    .osc_clk (osc_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  // Drive control pulses for one cycle with no sample.
  task automatic ctrl(input logic a, input logic f, input logic k);
    bus.arm = a; bus.force_trig = f; bus.frame_ack = k;
    tick();
    bus.arm = 1'b0; bus.force_trig = 1'b0; bus.frame_ack = 1'b0;
  endtask

  // Feed one sample that must be written at the model pointer.
  task automatic feed(input logic [7:0] d, input string tag);
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    tick();
    bus.sample_valid = 1'b0;
    chk({tag, "_we"},   32'(bus.buf_we),   32'd1);
    chk({tag, "_addr"}, 32'(bus.buf_addr), 32'(exp_ptr));
    chk({tag, "_data"}, 32'(bus.buf_data), 32'(d));
    exp_ptr = exp_ptr + 4'd1;
  endtask

  task automatic set_trig(input logic [7:0] lvl, input logic [7:0] hy, input logic sl);
    bus.trig_level = lvl; bus.trig_hyst = hy; bus.trig_slope = sl;
  endtask

  initial begin
    bus.sample_valid = 1'b0; bus.sample_data = '0;
    bus.arm = 1'b0; bus.force_trig = 1'b0; bus.frame_ack = 1'b0;
    set_trig(8'd128, 8'd4, 1'b1);

    #12;
    chk("rst_we",    32'(bus.buf_we),      32'd0);
    chk("rst_ready", 32'(bus.frame_ready), 32'd0);
    chk("rst_state", 32'(bus.cap_state),   32'd0);
    @(negedge osc_clk);
    reset = 1'b1;
    tick();

    // Rising trigger; the boundary sample 3 must not set hyst_ok.
    ctrl(1'b1, 1'b0, 1'b0);
    chk("t2_pretrig", 32'(bus.cap_state), 32'd1);
    for (int i = 0; i < 4; i++) feed(8'(i), "t2_pre");
    chk("t2_armed", 32'(bus.cap_state), 32'd2);
    tick();
    chk("t2_idle_we", 32'(bus.buf_we), 32'd0);
    feed(8'd130, "t2_s130");
    chk("t2_130_notrig", 32'(bus.cap_state), 32'd2);
    feed(8'd120, "t2_s120");
    chk("t2_120_notrig", 32'(bus.cap_state), 32'd2);
    feed(8'd129, "t2_s129");
    chk("t2_post", 32'(bus.cap_state), 32'd3);
    chk("t2_trig_addr", 32'(bus.trig_addr), 32'd6);
    for (int i = 0; i < 10; i++) feed(8'(200 + i), "t2_post");
    chk("t2_not_ready", 32'(bus.frame_ready), 32'd0);
    feed(8'd99, "t2_last");
    chk("t2_last_addr", 32'(bus.buf_addr), 32'd1);
    tick();
    chk("t2_ready", 32'(bus.frame_ready), 32'd1);
    chk("t2_done",  32'(bus.cap_state),   32'd4);

    // Hold in DONE, then acknowledge and re-arm together.
    for (int i = 0; i < 20; i++) begin
      bus.sample_valid = 1'b1; bus.sample_data = 8'(i);
      tick();
      chk("t5_done_we", 32'(bus.buf_we), 32'd0);
    end
    bus.sample_valid = 1'b0;
    chk("t5_hold_ready", 32'(bus.frame_ready), 32'd1);
    ctrl(1'b1, 1'b0, 1'b1);
    chk("t5_rearm_state", 32'(bus.cap_state),   32'd1);
    chk("t5_rearm_ready", 32'(bus.frame_ready), 32'd0);

    // Force trigger: ignored in PRETRIG, honoured in ARMED.
    feed(8'd50, "t4_pre");
    feed(8'd50, "t4_pre");
    ctrl(1'b0, 1'b1, 1'b0);
    feed(8'd50, "t4_pre");
    feed(8'd50, "t4_pre");
    chk("t4_armed", 32'(bus.cap_state), 32'd2);
    for (int i = 0; i < 3; i++) feed(8'd50, "t4_arm");
    chk("t4_no_force", 32'(bus.cap_state), 32'd2);
    ctrl(1'b0, 1'b1, 1'b0);
    chk("t4_pend", 32'(bus.cap_state), 32'd2);
    feed(8'd50, "t4_trig");
    chk("t4_post", 32'(bus.cap_state), 32'd3);
    chk("t4_trig_addr", 32'(bus.trig_addr), 32'd9);
    for (int i = 0; i < 11; i++) feed(8'd50, "t4_post");
    chk("t4_done", 32'(bus.cap_state), 32'd4);
    ctrl(1'b0, 1'b0, 1'b1);
    chk("t4_idle", 32'(bus.cap_state),   32'd0);
    chk("t4_clr",  32'(bus.frame_ready), 32'd0);

    // Falling trigger with saturated upper band, plus stray arm/ack.
    set_trig(8'd250, 8'd10, 1'b0);
    ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) feed(8'd100, "t3_pre");
    feed(8'd249, "t3_s249a");
    chk("t3_nohyst", 32'(bus.cap_state), 32'd2);
    ctrl(1'b1, 1'b0, 1'b1);
    chk("t6_stray_armed", 32'(bus.cap_state), 32'd2);
    feed(8'd254, "t3_s254");
    chk("t3_254_notrig", 32'(bus.cap_state), 32'd2);
    feed(8'd255, "t3_s255");
    chk("t3_255_notrig", 32'(bus.cap_state), 32'd2);
    feed(8'd249, "t3_s249b");
    chk("t3_post", 32'(bus.cap_state), 32'd3);
    chk("t3_trig_addr", 32'(bus.trig_addr), 32'd12);
    ctrl(1'b1, 1'b0, 1'b1);
    chk("t6_stray_post", 32'(bus.cap_state), 32'd3);
    for (int i = 0; i < 11; i++) feed(8'(i), "t3_post");
    chk("t3_last_addr", 32'(bus.buf_addr), 32'd7);
    tick();
    chk("t3_ready", 32'(bus.frame_ready), 32'd1);

    // Asynchronous reset in the middle of POST.
    ctrl(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) feed(8'd10, "t1_pre");
    ctrl(1'b0, 1'b1, 1'b0);
    feed(8'd10, "t1_trig");
    feed(8'd11, "t1_post");
    chk("t1_in_post", 32'(bus.cap_state), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_we",    32'(bus.buf_we),      32'd0);
    chk("t1_addr",  32'(bus.buf_addr),    32'd0);
    chk("t1_data",  32'(bus.buf_data),    32'd0);
    chk("t1_taddr", 32'(bus.trig_addr),   32'd0);
    chk("t1_ready", 32'(bus.frame_ready), 32'd0);
    chk("t1_state", 32'(bus.cap_state),   32'd0);
    @(negedge osc_clk);
    reset = 1'b1;
    tick();
    chk("t1_idle_after", 32'(bus.cap_state), 32'd0);
    exp_ptr = '0;
    ctrl(1'b1, 1'b0, 1'b0);
    feed(8'd77, "t1_ptr0");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
